// File: rtl/lcd_pkg.sv
// ----------------------------------------------------------------------------
// lcd_pkg
//   Shared types and constants for the LCD command scheduler:
//   - lcd_state_e : scheduler FSM state encoding
//   - LCD_INIT_ROM: HD44780 init sequence (8-bit/2-line, display on,
//                   entry mode increment, clear)
//   - RS_CMD/RS_DATA: register-select values seen by the byte writer
// ----------------------------------------------------------------------------
package lcd_pkg;

    typedef enum logic [2:0] {
        StPwrup     = 3'd0,
        StInitIssue = 3'd1,
        StInitWait  = 3'd2,
        StIdle      = 3'd3,
        StIssue     = 3'd4,
        StWait      = 3'd5
    } lcd_state_e;

    localparam int unsigned LCD_INIT_LEN = 4;

    localparam logic [7:0] LCD_INIT_ROM [0:3] = '{8'h38, 8'h0C, 8'h06, 8'h01};

    // Index of the final init byte; reaching it ends the init phase.
    localparam logic [1:0] LCD_INIT_LAST = 2'(LCD_INIT_LEN - 1);

    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_DATA = 1'b1;

endpackage

// File: rtl/lcd_rr_arbiter.sv
// ----------------------------------------------------------------------------
// lcd_rr_arbiter
//   Two-way round-robin grant. Purely combinational; the caller owns the
//   last-grant register and updates it when the grant is taken.
// Ports:
//   i_req0, i_req1  : pending requests
//   i_last_grant    : port that received the previous grant
//   o_grant_valid   : at least one request is pending
//   o_grant         : port to serve (0 or 1), meaningful when o_grant_valid
// ----------------------------------------------------------------------------
module lcd_rr_arbiter (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_grant,
    output logic o_grant_valid,
    output logic o_grant
);

    always_comb begin
        o_grant_valid = i_req0 | i_req1;
        if (i_req0 && i_req1) begin
            // Contention: hand the byte to whoever was not served last.
            o_grant = ~i_last_grant;
        end else begin
            o_grant = i_req1;
        end
    end

endmodule

// File: rtl/lcd_cmd_scheduler.sv
// ----------------------------------------------------------------------------
// lcd_cmd_scheduler
//   Front end for an HD44780-style byte writer (start/done handshake).
//   After reset it waits out LCD power-up, replays the init ROM, then
//   round-robin arbitrates two requesters, issuing one byte at a time and
//   acknowledging the owning requester when the writer reports done (or
//   when the write times out).
// Parameters:
//   POWERUP_CYCLES : clocks waited after reset before the first init byte
//   TIMEOUT_CYCLES : clocks from wr_start to forced completion; 0 disables
//   CNT_W          : width of the shared wait/timeout counter
// Ports:
//   i_clk, i_reset                : clock, async active-low reset
//   i_reqN / i_reqN_rs / _data    : requester N level request, RS, byte
//   o_ackN                        : 1-cycle completion pulse to requester N
//   o_wr_start/o_wr_rs/o_wr_data  : start pulse and operands to the writer
//   i_wr_done                     : writer completion pulse
//   o_init_done                   : init ROM has completed
//   o_busy                        : write outstanding, pending, or init running
//   o_err                         : sticky timeout flag
// ----------------------------------------------------------------------------
module lcd_cmd_scheduler
    import lcd_pkg::*;
#(
    parameter int unsigned POWERUP_CYCLES = 750000,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned CNT_W          = 20
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_req0,
    input  logic       i_req0_rs,
    input  logic [7:0] i_req0_data,
    output logic       o_ack0,
    input  logic       i_req1,
    input  logic       i_req1_rs,
    input  logic [7:0] i_req1_data,
    output logic       o_ack1,
    output logic       o_wr_start,
    output logic       o_wr_rs,
    output logic [7:0] o_wr_data,
    input  logic       i_wr_done,
    output logic       o_init_done,
    output logic       o_busy,
    output logic       o_err
);

    localparam logic [CNT_W-1:0] PWRUP_LAST =
        (POWERUP_CYCLES == 0) ? '0 : CNT_W'(POWERUP_CYCLES - 1);
    // Counter is 0 in the cycle wr_start is visible, so expiry is detected
    // one count early to land the ack exactly TIMEOUT_CYCLES after start.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    lcd_state_e       r_state,      w_state_d;
    logic [CNT_W-1:0] r_cnt,        w_cnt_d;
    logic [1:0]       r_rom_idx,    w_rom_idx_d;
    logic             r_last_grant, w_last_grant_d;
    logic             r_wr_start,   w_wr_start_d;
    logic             r_wr_rs,      w_wr_rs_d;
    logic [7:0]       r_wr_data,    w_wr_data_d;
    logic             r_ack0,       w_ack0_d;
    logic             r_ack1,       w_ack1_d;
    logic             r_init_done,  w_init_done_d;
    logic             r_err,        w_err_d;

    logic             w_grant_valid;
    logic             w_grant;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_timeout;

    lcd_rr_arbiter u_arb (
        .i_req0        (i_req0),
        .i_req1        (i_req1),
        .i_last_grant  (r_last_grant),
        .o_grant_valid (w_grant_valid),
        .o_grant       (w_grant)
    );

    // Saturating increment: the counter never wraps back to a small value.
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt >= TIMEOUT_LAST);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= StPwrup;
            r_cnt        <= '0;
            r_rom_idx    <= '0;
            r_last_grant <= 1'b1;
            r_wr_start   <= 1'b0;
            r_wr_rs      <= 1'b0;
            r_wr_data    <= '0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_init_done  <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_cnt        <= w_cnt_d;
            r_rom_idx    <= w_rom_idx_d;
            r_last_grant <= w_last_grant_d;
            r_wr_start   <= w_wr_start_d;
            r_wr_rs      <= w_wr_rs_d;
            r_wr_data    <= w_wr_data_d;
            r_ack0       <= w_ack0_d;
            r_ack1       <= w_ack1_d;
            r_init_done  <= w_init_done_d;
            r_err        <= w_err_d;
        end
    end

    always_comb begin
        w_state_d      = r_state;
        w_cnt_d        = r_cnt;
        w_rom_idx_d    = r_rom_idx;
        w_last_grant_d = r_last_grant;
        w_wr_start_d   = 1'b0;
        w_wr_rs_d      = r_wr_rs;
        w_wr_data_d    = r_wr_data;
        w_ack0_d       = 1'b0;
        w_ack1_d       = 1'b0;
        w_init_done_d  = r_init_done;
        w_err_d        = r_err;

        unique case (r_state)
            StPwrup: begin
                if (r_cnt >= PWRUP_LAST) begin
                    w_state_d = StInitIssue;
                end else begin
                    w_cnt_d = w_cnt_inc;
                end
            end

            StInitIssue: begin
                w_wr_rs_d    = RS_CMD;
                w_wr_data_d  = LCD_INIT_ROM[r_rom_idx];
                w_wr_start_d = 1'b1;
                w_cnt_d      = '0;
                w_state_d    = StInitWait;
            end

            StInitWait: begin
                w_cnt_d = w_cnt_inc;
                // A done arriving together with expiry wins: no error.
                if (i_wr_done || w_timeout) begin
                    if (!i_wr_done) begin
                        w_err_d = 1'b1;
                    end
                    if (r_rom_idx == LCD_INIT_LAST) begin
                        w_init_done_d = 1'b1;
                        w_state_d     = StIdle;
                    end else begin
                        w_rom_idx_d = r_rom_idx + 2'd1;
                        w_state_d   = StInitIssue;
                    end
                end
            end

            StIdle: begin
                if (w_grant_valid) begin
                    w_last_grant_d = w_grant;
                    w_wr_rs_d      = w_grant ? i_req1_rs   : i_req0_rs;
                    w_wr_data_d    = w_grant ? i_req1_data : i_req0_data;
                    w_state_d      = StIssue;
                end
            end

            StIssue: begin
                w_wr_start_d = 1'b1;
                w_cnt_d      = '0;
                w_state_d    = StWait;
            end

            StWait: begin
                w_cnt_d = w_cnt_inc;
                if (i_wr_done || w_timeout) begin
                    if (!i_wr_done) begin
                        w_err_d = 1'b1;
                    end
                    // r_last_grant still names the owner of the byte in flight.
                    w_ack0_d  = ~r_last_grant;
                    w_ack1_d  = r_last_grant;
                    w_state_d = StIdle;
                end
            end

            default: begin
                w_state_d = StPwrup;
            end
        endcase
    end

    assign o_wr_start  = r_wr_start;
    assign o_wr_rs     = r_wr_rs;
    assign o_wr_data   = r_wr_data;
    assign o_ack0      = r_ack0;
    assign o_ack1      = r_ack1;
    assign o_init_done = r_init_done;
    assign o_err       = r_err;
    // Idle with a request pending is about to grant, so it still counts as busy.
    assign o_busy      = !((r_state == StIdle) && !i_req0 && !i_req1);

endmodule

// File: tb/tb_lcd_cmd_scheduler.sv
// ----------------------------------------------------------------------------
// tb_lcd_cmd_scheduler
//   Self-checking bench for lcd_cmd_scheduler (POWERUP=10, TIMEOUT=20).
//   A transaction-level model predicts, from the request levels seen while
//   the scheduler is free, which byte starts when, when each ack lands and
//   whether err is set. The writer model returns done a chosen number of
//   cycles after each start, or never.
// ----------------------------------------------------------------------------
module tb_lcd_cmd_scheduler;

    localparam int P     = 10;
    localparam int T     = 20;
    localparam int NEVER = 1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req0_rs = 1'b0, req1 = 1'b0, req1_rs = 1'b0;
    logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
    logic       wr_done = 1'b0;
    logic       ack0, ack1, wr_start, wr_rs, init_done, busy, err;
    logic [7:0] wr_data;

    always #5 clk = ~clk;

    lcd_cmd_scheduler #(
        .POWERUP_CYCLES (P),
        .TIMEOUT_CYCLES (T),
        .CNT_W          (20)
    ) u_dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_req0      (req0),
        .i_req0_rs   (req0_rs),
        .i_req0_data (req0_data),
        .o_ack0      (ack0),
        .i_req1      (req1),
        .i_req1_rs   (req1_rs),
        .i_req1_data (req1_data),
        .o_ack1      (ack1),
        .o_wr_start  (wr_start),
        .o_wr_rs     (wr_rs),
        .o_wr_data   (wr_data),
        .i_wr_done   (wr_done),
        .o_init_done (init_done),
        .o_busy      (busy),
        .o_err       (err)
    );

    logic [7:0] rom [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};

    int n_chk = 0;
    int n_err = 0;
    int cyc;

    // Reference model state.
    bit         m_init, m_idle, m_last, m_err;
    int         m_rom_idx;
    int         exp_start, exp_port;
    logic [7:0] exp_data;
    logic       exp_rs;
    int         resp_cyc, resp_port, done_cyc;
    bit         resp_err, resp_init;

    // Stimulus control and observations.
    int wr_mode;     // 0: done after 5, 1: random, 2: never
    int req_policy;  // 0: drop on ack, 1: hold, 2: random traffic
    int last_start_cyc, last_ack_cyc, init_done_cyc, first_init_start;
    int phase_starts;
    int aseq[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pick_delay();
        int r;
        if (wr_mode == 0) return 5;
        if (wr_mode == 2) return NEVER;
        r = $urandom_range(0, 9);
        if (r < 5) return 5;
        if (r < 8) return $urandom_range(1, 18);
        if (r == 8) return T - 1;  // done lands on the expiry cycle
        return NEVER;
    endfunction

    task automatic model_reset();
        m_init = 1; m_idle = 0; m_last = 1; m_err = 0; m_rom_idx = 0;
        exp_start = P + 1; exp_port = -1;
        resp_cyc = -1; done_cyc = -1;
        cyc = 0;
    endtask

    task automatic update_port(input bit acked, inout logic req, inout logic rs,
                               inout logic [7:0] data);
        case (req_policy)
            0: if (acked) req = 1'b0;
            1: ;
            default: begin
                if (acked) begin
                    if ($urandom_range(0, 1) == 1) req = 1'b0;
                    else begin data = 8'($urandom); rs = 1'($urandom); end
                end else if (!req) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req = 1'b1; data = 8'($urandom); rs = 1'($urandom);
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    data = 8'($urandom); rs = 1'($urandom);
                end
            end
        endcase
    endtask

    // One clock: check busy and take the grant decision on the inputs of the
    // current cycle, advance, then check everything registered at the edge.
    task automatic tick();
        bit ea0, ea1, a0, a1;
        int d;
        #1;
        check_eq("busy", busy, !(m_idle && !req0 && !req1));
        if (m_idle && (req0 || req1)) begin
            exp_port  = (req0 && req1) ? (m_last ? 0 : 1) : (req1 ? 1 : 0);
            m_last    = (exp_port == 1);
            exp_data  = (exp_port == 1) ? req1_data : req0_data;
            exp_rs    = (exp_port == 1) ? req1_rs : req0_rs;
            exp_start = cyc + 2;
            m_idle    = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        ea0 = 0; ea1 = 0;
        if (cyc == resp_cyc) begin
            resp_cyc = -1;
            if (resp_err) m_err = 1;
            if (resp_init) begin
                if (m_rom_idx == 3) begin
                    m_init = 0; m_idle = 1; init_done_cyc = cyc;
                end else begin
                    m_rom_idx++;
                    exp_start = cyc + 1;
                end
            end else begin
                ea0 = (resp_port == 0); ea1 = (resp_port == 1); m_idle = 1;
            end
        end
        a0 = ack0; a1 = ack1;
        check_eq("ack0", a0, ea0);
        check_eq("ack1", a1, ea1);
        if (a0) aseq.push_back(0);
        if (a1) aseq.push_back(1);
        if (a0 || a1) last_ack_cyc = cyc;
        check_eq("init_done", init_done, !m_init);
        check_eq("err", err, m_err);
        check_eq("wr_start", wr_start, cyc == exp_start);
        if (cyc == exp_start) begin
            if (m_init) begin
                check_eq("init_data", wr_data, rom[m_rom_idx]);
                check_eq("init_rs", wr_rs, 0);
                if (m_rom_idx == 0) first_init_start = cyc;
            end else begin
                check_eq("wr_data", wr_data, exp_data);
                check_eq("wr_rs", wr_rs, exp_rs);
                phase_starts++;
            end
            resp_init = m_init; resp_port = exp_port; last_start_cyc = cyc;
            d = pick_delay();
            if (d >= NEVER) begin
                done_cyc = -1; resp_err = 1; resp_cyc = cyc + T;
            end else begin
                done_cyc = cyc + d; resp_err = 0; resp_cyc = cyc + d + 1;
            end
            exp_start = -1;
        end
        wr_done = (cyc == done_cyc);
        update_port(a0, req0, req0_rs, req0_data);
        update_port(a1, req1, req1_rs, req1_data);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && !(m_idle && !req0 && !req1 && resp_cyc < 0); i++) tick();
        check_eq("idle_reached", m_idle && !req0 && !req1 && resp_cyc < 0, 1);
    endtask

    initial begin
        model_reset();
        wr_mode = 0; req_policy = 0;
        last_start_cyc = -1; last_ack_cyc = -1; init_done_cyc = -1; first_init_start = -1;
        phase_starts = 0;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_wr_start", wr_start, 0);
        check_eq("rst_busy", busy, 1);
        check_eq("rst_init_done", init_done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_ack", {ack1, ack0}, 0);
        check_eq("rst_wr_data", wr_data, 0);
        rst_n = 1'b1;
        cyc = 0;

        // Power-up wait and init ROM replay.
        for (int i = 0; i < 100 && m_init; i++) tick();
        check_eq("first_init_start", first_init_start, 11);
        check_eq("init_done_cycle", init_done_cyc, 38);

        // Both requesters held: strict alternation starting with port 0.
        aseq.delete(); phase_starts = 0; req_policy = 1;
        req0 = 1; req0_rs = 0; req0_data = 8'hA5;
        req1 = 1; req1_rs = 1; req1_data = 8'h3C;
        for (int i = 0; i < 200 && phase_starts < 4; i++) tick();
        req0 = 0; req1 = 0; req_policy = 0;
        wait_idle();
        check_eq("grant_count", aseq.size(), 4);
        for (int k = 0; k < 4; k++) begin
            check_eq("grant_order", (k < aseq.size()) ? aseq[k] : -1, k % 2);
        end

        // Single requester 1, data byte.
        aseq.delete();
        req1 = 1; req1_rs = 1; req1_data = 8'h41;
        wait_idle();
        check_eq("req1_only_acks", aseq.size(), 1);
        check_eq("req1_only_port", (aseq.size() > 0) ? aseq[0] : -1, 1);

        // Writer never answers: forced completion and sticky err.
        wr_mode = 2; last_start_cyc = -1; last_ack_cyc = -1;
        req0 = 1; req0_rs = 0; req0_data = 8'h77;
        wait_idle();
        wr_mode = 0;
        check_eq("timeout_latency", last_ack_cyc - last_start_cyc, T);
        check_eq("timeout_err", err, 1);

        // Service continues after a timeout.
        aseq.delete();
        req1 = 1; req1_rs = 0; req1_data = 8'h42;
        wait_idle();
        check_eq("post_timeout_ack", (aseq.size() > 0) ? aseq[0] : -1, 1);

        // Random traffic with random writer latency.
        req_policy = 2; wr_mode = 1;
        repeat (400) tick();
        req_policy = 0;
        wait_idle();
        wr_mode = 0;

        // Reset while a byte is in flight.
        last_start_cyc = -1;
        req0 = 1; req0_rs = 1; req0_data = 8'h99;
        for (int i = 0; i < 50 && !(last_start_cyc >= 0 && cyc == last_start_cyc + 2); i++)
            tick();
        check_eq("reached_wait", cyc - last_start_cyc, 2);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_wr_start", wr_start, 0);
        check_eq("mid_rst_wr_data", wr_data, 0);
        check_eq("mid_rst_wr_rs", wr_rs, 0);
        check_eq("mid_rst_init_done", init_done, 0);
        check_eq("mid_rst_busy", busy, 1);
        check_eq("mid_rst_err", err, 0);
        req0 = 0; wr_done = 0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("mid_rst_no_ack", {ack1, ack0}, 0);
        rst_n = 1'b1;
        model_reset();
        first_init_start = -1;

        // Request raised during init is served right after init completes.
        for (int i = 0; i < 30 && cyc < 20; i++) tick();
        req0 = 1; req0_rs = 1; req0_data = 8'h5A;
        for (int i = 0; i < 100 && m_init; i++) tick();
        wait_idle();
        check_eq("reinit_first_start", first_init_start, 11);
        check_eq("post_init_grant", last_start_cyc - init_done_cyc, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
